// File: rtl/sdrc_bank_req_fifo.sv
// In-order chunk queue, request generator -> bank FSMs; show-ahead, 1-cycle latency, full holds off b2r_ack.
// Optional `SDRC_REQ_FIFO_BYPASS_EN: an empty queue passes a chunk straight through when q_ready is high.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif
`ifndef REQ_BW
`define REQ_BW 7
`endif

module sdrc_bank_req_fifo #(
   parameter int DEPTH      = 4,
   parameter int AFULL_ROOM = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     r2b_req,
   input  logic [`SDR_REQ_ID_W-1:0] r2b_req_id,
   input  logic                     r2b_start,
   input  logic                     r2b_last,
   input  logic                     r2b_wrap,
   input  logic [1:0]               r2b_ba,
   input  logic [12:0]              r2b_raddr,
   input  logic [12:0]              r2b_caddr,
   input  logic [`REQ_BW-1:0]       r2b_len,
   input  logic                     r2b_write,
   output logic                     b2r_ack,
   output logic                     b2r_arb_ok,
   output logic                     q_valid,
   input  logic                     q_ready,
   output logic [`SDR_REQ_ID_W-1:0] q_req_id,
   output logic                     q_start,
   output logic                     q_last,
   output logic                     q_wrap,
   output logic [1:0]               q_ba,
   output logic [12:0]              q_raddr,
   output logic [12:0]              q_caddr,
   output logic [`REQ_BW-1:0]       q_len,
   output logic                     q_write,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0] ROOM_C  = AFULL_ROOM[AW:0];

   typedef struct packed {
      logic [`SDR_REQ_ID_W-1:0] req_id;
      logic                     start;
      logic                     last;
      logic                     wrap;
      logic [1:0]               ba;
      logic [12:0]              raddr;
      logic [12:0]              caddr;
      logic [`REQ_BW-1:0]       len;
      logic                     write;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        in_ent;
   entry_t        head;
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          byp;

   assign in_ent = {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_ba,
                    r2b_raddr, r2b_caddr, r2b_len, r2b_write};
   assign full   = (cnt == DEPTH_C);
   assign empty  = (cnt == '0);

`ifdef SDRC_REQ_FIFO_BYPASS_EN
   assign byp = empty & r2b_req & q_ready & ~reset;
`else
   assign byp = 1'b0;
`endif

   // Full blocks the push regardless of a same-cycle pop: no q_ready -> b2r_ack path.
   assign b2r_ack    = r2b_req & ~full & ~reset;
   assign push       = b2r_ack & ~byp;
   assign pop        = ~empty & q_ready;
   assign q_valid    = ~empty | byp;
   assign head       = byp ? in_ent : mem[rp];
   assign fifo_level = cnt;
   assign b2r_arb_ok = (DEPTH_C - cnt) >= ROOM_C;

   assign {q_req_id, q_start, q_last, q_wrap, q_ba,
           q_raddr, q_caddr, q_len, q_write} = head;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= in_ent;
   end

endmodule
